// File: rtl/receiver_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : receiver_buffer_pkg
//  Description : Shared types for the UART receive word buffer: byte and word
//                types plus the byte-assembler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package receiver_buffer_pkg;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;

    // Which byte of the current word the assembler expects next.
    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
    } asm_state_e;

endpackage
`default_nettype wire

// File: rtl/word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : word_fifo
//  Description : First-word fall-through FIFO of 32-bit words. Occupancy is
//                tracked by a counter, so full/empty never depend on pointer
//                equality. A push into a full FIFO is accepted only when a pop
//                happens in the same cycle; a pop of an empty FIFO is ignored.
//  Ports       : CLK, reset (async, active-high)
//                push/wdata  - write request and word
//                pop         - read request (pops head when not empty)
//                rdata       - head word (0 while empty)
//                count       - stored words, 0..DEPTH
//                full, empty - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module word_fifo
    import receiver_buffer_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  word_t                  wdata,
    output word_t                  rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int c_AW = $clog2(DEPTH);

    word_t             r_mem [DEPTH];
    logic [c_AW-1:0]   r_head;
    logic [c_AW-1:0]   r_tail;
    logic [c_AW:0]     r_count;

    logic              w_do_pop;
    logic              w_do_push;

    assign full  = (r_count == (c_AW+1)'(DEPTH));
    assign empty = (r_count == '0);

    assign w_do_pop  = pop & ~empty;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_pop) begin
                r_head <= r_head + c_AW'(1);
            end
            if (w_do_push) begin
                r_tail <= r_tail + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers and count define contents.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_tail] <= wdata;
        end
    end

    // Force the head to zero while empty so the output is defined after reset.
    assign rdata = empty ? '0 : r_mem[r_head];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/receiver_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : receiver_buffer
//  Description : Packs UART bytes MSB-first into 32-bit words and queues them
//                in a first-word fall-through FIFO. A word completing while the
//                FIFO is full (and no pop) is dropped and the sticky overflow
//                flag is set.
//  Config      : RECEIVER_BUFFER_RX_TIMEOUT_EN - when defined, a partial word
//                idle for TIMEOUT_CYCLES clocks is discarded. When undefined a
//                partial word waits indefinitely.
//  Ports       : CLK, reset (async, active-high)
//                input_data/input_valid - received byte and strobe
//                read_req               - pop one word
//                data/valid             - head word and its qualifier
//                count                  - stored words
//                overflow               - sticky word-dropped flag
//  Revision    : 1.0 - initial release
// ============================================================================
module receiver_buffer
    import receiver_buffer_pkg::*;
#(
    parameter int DEPTH          = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  byte_t                  input_data,
    input  logic                   input_valid,
    input  logic                   read_req,
    output word_t                  data,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    asm_state_e  r_state;
    logic [23:0] r_partial;
    logic        r_overflow;

    logic        w_word_done;
    word_t       w_word;
    logic        w_full;
    logic        w_empty;
    logic        w_timeout;

    assign w_word_done = input_valid && (r_state == BYTE3);
    // The last byte joins the word combinationally so it is pushed on its own edge.
    assign w_word      = {r_partial, input_data};

`ifdef RECEIVER_BUFFER_RX_TIMEOUT_EN
    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TW-1:0] r_idle_cnt;

    // A strobe in the expiry cycle takes priority, hence the input_valid term.
    assign w_timeout = (r_state != BYTE0) && !input_valid &&
                       (r_idle_cnt == c_TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (input_valid || (r_state == BYTE0) || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + c_TW'(1);
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= BYTE0;
            r_partial <= '0;
        end else if (input_valid) begin
            case (r_state)
                BYTE0: begin
                    r_partial[23:16] <= input_data;
                    r_state          <= BYTE1;
                end
                BYTE1: begin
                    r_partial[15:8] <= input_data;
                    r_state         <= BYTE2;
                end
                BYTE2: begin
                    r_partial[7:0] <= input_data;
                    r_state        <= BYTE3;
                end
                BYTE3: begin
                    r_partial <= '0;
                    r_state   <= BYTE0;
                end
                default: begin
                    r_partial <= '0;
                    r_state   <= BYTE0;
                end
            endcase
        end else if (w_timeout) begin
            r_partial <= '0;
            r_state   <= BYTE0;
        end
    end

    // Full implies valid, so read_req here is always an effective pop.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_word_done && w_full && !read_req) begin
            r_overflow <= 1'b1;
        end
    end

    word_fifo #(
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (w_word_done),
        .pop   (read_req),
        .wdata (w_word),
        .rdata (data),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign valid    = ~w_empty;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_receiver_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_receiver_buffer
//  Description : Self-checking bench for receiver_buffer (DEPTH=32,
//                TIMEOUT_CYCLES=16). A byte-assembly/queue model pushes
//                expected words when stimulus is driven; the head is compared
//                every cycle. Table vectors and directed corner sequences
//                add explicit constant expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_receiver_buffer;
    import receiver_buffer_pkg::*;

    localparam int DEPTH = 32;
    localparam int TO    = 16;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    byte_t       input_data = '0;
    logic        input_valid = 1'b0;
    logic        read_req = 1'b0;
    word_t       data;
    logic        valid;
    logic [5:0]  count;
    logic        overflow;

    always #5 CLK = ~CLK;

    receiver_buffer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .input_data  (input_data),
        .input_valid (input_valid),
        .read_req    (read_req),
        .data        (data),
        .valid       (valid),
        .count       (count),
        .overflow    (overflow)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    word_t       sb[$];
    int          m_state;
    logic [23:0] m_part;
    logic        m_ovf;
    int          m_idle;

    typedef struct {
        byte_t b[4];
        word_t exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_state = 0;
        m_part  = '0;
        m_ovf   = 1'b0;
        m_idle  = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic vb, input byte_t b, input logic rd);
        word_t w;
        input_valid = vb;
        input_data  = b;
        read_req    = rd;
        chk("valid", {31'd0, valid}, {31'd0, sb.size() > 0});
        chk("count", {26'd0, count}, sb.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (sb.size() > 0) chk("head", data, sb[0]);
        if (rd && sb.size() > 0) void'(sb.pop_front());
        if (vb) begin
            m_idle = 0;
            case (m_state)
                0: m_part[23:16] = b;
                1: m_part[15:8]  = b;
                2: m_part[7:0]   = b;
                default: begin
                    w = {m_part, b};
                    if (sb.size() < DEPTH) sb.push_back(w);
                    else m_ovf = 1'b1;
                    m_part = '0;
                end
            endcase
            m_state = (m_state + 1) % 4;
        end else if (m_state != 0) begin
`ifdef RECEIVER_BUFFER_RX_TIMEOUT_EN
            if (m_idle == TO - 1) begin
                m_state = 0;
                m_part  = '0;
                m_idle  = 0;
            end else begin
                m_idle++;
            end
`endif
        end
        @(posedge CLK);
        #1;
        input_valid = 1'b0;
        read_req    = 1'b0;
    endtask

    task automatic send_word(input word_t w, input logic rd_last);
        cycle(1'b1, w[31:24], 1'b0);
        cycle(1'b1, w[23:16], 1'b0);
        cycle(1'b1, w[15:8],  1'b0);
        cycle(1'b1, w[7:0],   rd_last);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_count", {26'd0, count}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_data", data, 32'd0);
        @(posedge CLK);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; vecs[0].exp = 32'hDEADBEEF;
        vecs[1].b = '{8'h12, 8'h34, 8'h56, 8'h78}; vecs[1].exp = 32'h12345678;
        vecs[2].b = '{8'hFF, 8'h00, 8'hFF, 8'h00}; vecs[2].exp = 32'hFF00FF00;
        vecs[3].b = '{8'hA5, 8'h5A, 8'hC3, 8'h3C}; vecs[3].exp = 32'hA55AC33C;
        vecs[4].b = '{8'h00, 8'h00, 8'h00, 8'h01}; vecs[4].exp = 32'h00000001;

        model_reset();
        #2;
        do_reset();

        // Table vectors: assemble, check packing and 1-cycle latency, pop.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) cycle(1'b1, vecs[i].b[j], 1'b0);
            chk("vec_valid", {31'd0, valid}, 32'd1);
            chk("vec_data", data, vecs[i].exp);
            chk("vec_count", {26'd0, count}, 32'd1);
            cycle(1'b0, 8'h00, 1'b1);
            chk("vec_popped", {26'd0, count}, 32'd0);
        end

        // 33 words into a 32-deep buffer: last one dropped, overflow sticks.
        for (int i = 0; i <= 32; i++) send_word(word_t'(i), 1'b0);
        chk("ovf_count", {26'd0, count}, 32'd32);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            chk("ovf_order", data, word_t'(i));
            cycle(1'b0, 8'h00, 1'b1);
        end
        chk("ovf_drained", {31'd0, valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full buffer with pop coinciding with the 4th byte: word accepted.
        do_reset();
        for (int i = 0; i < 32; i++) send_word(word_t'(i), 1'b0);
        send_word(32'h0000_0100, 1'b1);
        chk("fullpop_count", {26'd0, count}, 32'd32);
        chk("fullpop_ovf", {31'd0, overflow}, 32'd0);
        chk("fullpop_head", data, 32'd1);
        for (int i = 0; i < 32; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("fullpop_empty", {26'd0, count}, 32'd0);

        // Reads on an empty buffer are ignored.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("underflow_count", {26'd0, count}, 32'd0);
        send_word(32'hCAFE_F00D, 1'b0);
        chk("underflow_data", data, 32'hCAFEF00D);
        cycle(1'b0, 8'h00, 1'b1);
        chk("underflow_pop", {26'd0, count}, 32'd0);
        // Empty buffer, read_req with the completing byte: push wins.
        send_word(32'h0BAD_BEEF, 1'b1);
        chk("emptypush_count", {26'd0, count}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);

        // Reset mid-word discards the partial bytes.
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        do_reset();
        send_word(32'hAABB_CCDD, 1'b0);
        chk("midrst_data", data, 32'hAABBCCDD);
        chk("midrst_count", {26'd0, count}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);

        // Random traffic, checked cycle by cycle against the model.
        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), byte_t'($urandom), 1'($urandom_range(0, 3) == 0));
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);

        // Idle gap after a partial word.
        do_reset();
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        idle(20);
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0);
        cycle(1'b1, 8'hCC, 1'b0);
        cycle(1'b1, 8'hDD, 1'b0);
`ifdef RECEIVER_BUFFER_RX_TIMEOUT_EN
        chk("timeout_data", data, 32'hAABBCCDD);
`else
        chk("timeout_data", data, 32'h1122AABB);
`endif
        chk("timeout_count", {26'd0, count}, 32'd1);
        chk("timeout_ovf", {31'd0, overflow}, 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/receiver_buffer.md
RECEIVER_BUFFER -- requirements
Module: receiver_buffer

Interface
REQ-001 Parameter DEPTH, default 32, meaning number of 32-bit word entries (power of two, 2..256).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, meaning idle CLK cycles before a partial word is discarded (used only under RX_TIMEOUT_EN).
REQ-003 Port CLK  input  1  sole clock, all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port input_data  input  8  byte from the UART receiver, sampled only when input_valid is high.
REQ-006 Port input_valid  input  1  single-cycle strobe, one per received byte.
REQ-007 Port read_req  input  1  consumer pop request, one word per high cycle.
REQ-008 Port data  output  32  head word of the buffer.
REQ-009 Port valid  output  1  high when at least one word is stored (data meaningful).
REQ-010 Port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-011 Port overflow  output  1  sticky flag, set when a completed word is dropped.

Function
REQ-012 Assembler SHALL be a 4-state FSM: BYTE0 -> BYTE1 -> BYTE2 -> BYTE3 -> BYTE0, advancing only on cycles with input_valid high.
REQ-013 Bytes SHALL be packed MSB-first: BYTE0 -> [31:24], BYTE1 -> [23:16], BYTE2 -> [15:8], BYTE3 -> [7:0].
REQ-014 On input_valid in BYTE3 the completed word SHALL be pushed in the same edge; valid SHALL rise in the next cycle if the buffer was empty (latency 1 cycle from 4th strobe).
REQ-015 Buffer SHALL be FIFO, first-word fall-through: data SHALL always show the oldest stored word; its value when valid is low is don't-care.
REQ-016 read_req high with valid high SHALL pop one word at that edge; read_req with valid low SHALL be ignored (no underflow, count stays 0).
REQ-017 Completed word while full and no pop SHALL be dropped, contents unchanged, overflow set to 1; overflow SHALL stay 1 until reset.
REQ-018 Completed word while full with simultaneous pop SHALL be accepted; count stays DEPTH, no overflow.
REQ-019 Completed word while empty with simultaneous read_req SHALL be pushed, pop ignored; count becomes 1.
REQ-020 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be derived from count, not pointer equality.
REQ-021 count SHALL change by +1, -1 or 0 per cycle and never exceed DEPTH.

Reset
REQ-022 On reset assertion (asynchronous): assembler -> BYTE0, partial word cleared, pointers 0, count 0, valid 0, overflow 0, data 0, timeout counter 0.
REQ-023 Reset mid-word or mid-operation SHALL discard all partial and stored words; storage array contents need not be cleared.
REQ-024 First push after reset deassertion SHALL be accepted on the first rising edge with reset low.

Configuration
REQ-025 Macro RECEIVER_BUFFER_RX_TIMEOUT_EN defined: a counter SHALL run while assembler is not in BYTE0, cleared on every input_valid; reaching TIMEOUT_CYCLES SHALL return the FSM to BYTE0 and discard the partial word without touching the FIFO or overflow.
REQ-026 Macro undefined: no timeout counter SHALL exist; a partial word SHALL wait indefinitely; TIMEOUT_CYCLES is ignored.
REQ-027 input_valid in the same cycle as the timeout SHALL win: byte accepted, counter cleared, no discard.

Structure
REQ-028 Package receiver_buffer_pkg SHALL hold word_t (32-bit), byte_t (8-bit) and the assembler state enum (BYTE0..BYTE3).
REQ-029 Storage SHALL be sub-module word_fifo (push, pop, wdata, rdata, count, full, empty), instantiated once; assembler, timeout and overflow logic stay in receiver_buffer.

Verification
REQ-030 Bytes 0xDE,0xAD,0xBE,0xEF strobed after reset -> one cycle after 4th strobe valid=1, data=0xDEADBEEF, count=1.
REQ-031 Push 33 words (values 0..32) with DEPTH=32, no reads -> count=32, overflow=1, pops return 0..31 in order, word 32 absent.
REQ-032 Full buffer, 4th byte strobed in same cycle as read_req -> count stays 32, overflow=0, head advances by one, new word last.
REQ-033 Empty buffer, read_req held high for 10 cycles -> valid=0, count=0 throughout; then one word pushed -> popped on next cycle, count returns to 0.
REQ-034 Two bytes 0x11,0x22, reset pulse, then 0xAA,0xBB,0xCC,0xDD -> data=0xAABBCCDD, count=1.
REQ-035 With RECEIVER_BUFFER_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: bytes 0x11,0x22, 20 idle cycles, then 0xAA,0xBB,0xCC,0xDD -> data=0xAABBCCDD, count=1, overflow=0.
